// File: rtl/div_pkg.sv
// Shared definitions for the sequential non-restoring divider: FSM states,
// add/subtract select encodings and the default operand width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/nr_addsub.sv
// Combinational W-bit ripple-carry adder/subtractor.
// op=OP_ADD gives a+b, op=OP_SUB gives a+~b+1.
module nr_addsub
  import div_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry_out
);

  logic [W-1:0] w_b;
  logic [W:0]   w_c;

  always_comb begin
    sum       = '0;
    w_c       = '0;
    w_b       = (op == OP_ADD) ? b : ~b;
    // Carry-in is the inverted select, completing the two's complement on subtract.
    w_c[0]    = ~op;
    for (int i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ w_b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & w_b[i]) | (w_c[i] & (a[i] ^ w_b[i]));
    end
    carry_out = w_c[W];
  end

endmodule

// File: rtl/nonrestoring_divider.sv
// Unsigned sequential non-restoring divider: one quotient bit per clock,
// start/busy/done handshake, results held until the next done.
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output state_t           dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           r_state;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_m;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic             w_op;
  logic [WIDTH:0]   w_a;
  logic [WIDTH:0]   w_sum;
  logic             w_carry_unused;

  // One adder serves both steps: shifted partial remainder in ITER, restore in FIX.
  always_comb begin
    w_op = OP_ADD;
    w_a  = r_a;
    if (r_state != FIX) begin
      w_op = r_a[WIDTH] ? OP_ADD : OP_SUB;
      w_a  = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    end
  end

  nr_addsub #(
    .W(WIDTH + 1)
  ) u_addsub (
    .op        (w_op),
    .a         (w_a),
    .b         (r_m),
    .sum       (w_sum),
    .carry_out (w_carry_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              r_a     <= '0;
              r_q     <= dividend;
              r_m     <= {1'b0, divisor};
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= ITER;
            end else begin
              r_quot <= '1;
              r_rem  <= dividend;
              r_dbz  <= 1'b1;
              r_done <= 1'b1;
            end
          end
        end
        ITER: begin
          r_a   <= w_sum;
          r_q   <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == LAST_CNT) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          if (r_a[WIDTH]) begin
            r_a <= w_sum;
          end
          r_quot  <= r_q;
          r_rem   <= r_a[WIDTH] ? w_sum[WIDTH-1:0] : r_a[WIDTH-1:0];
          r_dbz   <= 1'b0;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign dbg_state   = r_state;

endmodule
